merger_2_core: RTL and testbench
================================

# merger_2_core

Two-input, two-lane streaming merge element for the sorter merge tree. It pops 2×W-bit sorted tuples from two show-ahead input FIFOs and pushes merged, sorted 2×W-bit tuples into one output FIFO. Sequences are delimited by an all-zero terminator tuple. Each pair of input terminators produces exactly one output terminator, after which the block rearms for the next sequence pair.

## Interface
- W, default 32: element width. Tuples are 2W bits; lane 0 is [W-1:0], lane 1 is [2W-1:W].
- i_clk  in  1  clock; all state updates on the rising edge.
- i_rst_n  in  1  reset, asynchronous and active-low.
- i_fifo_1  in  2W  head tuple of input FIFO 1 (show-ahead); valid when !i_fifo_1_empty.
- i_fifo_1_empty  in  1  input FIFO 1 empty.
- i_fifo_2  in  2W  head tuple of input FIFO 2.
- i_fifo_2_empty  in  1  input FIFO 2 empty.
- i_fifo_out_ready  in  1  output FIFO accepts a write at the next edge.
- o_fifo_1_read  out  1  pop FIFO 1 at this edge (combinational).
- o_fifo_2_read  out  1  pop FIFO 2 at this edge (combinational).
- o_out_fifo_write  out  1  push o_data at this edge (combinational).
- o_data  out  2W  output tuple, lane 0 ≤ lane 1.

## Operation
- Input contract: each input tuple is ascending (lane0 ≤ lane1). Successive tuples in a stream are ascending. Data elements are nonzero unsigned. A tuple with both lanes zero is a terminator (T). In comparisons, T counts as +infinity.
- Registered state:
  - R: a 2-element leftover, sorted.
  - State: PRIME, MERGE or TERM.
- Action gate: an action is taken only when both FIFOs are non-empty. Actions that write additionally require i_fifo_out_racy... i_fifo_out_ready = 1. Otherwise all strobes are 0 and state holds.
- Selection: choose FIFO 1 if head1.lane0 ≤ head2.lane0 (ties go to FIFO 1), else FIFO 2. T is never selected over data.
- PRIME:
  - Both heads T: write 0, pop both, stay in PRIME.
  - Otherwise: pop the selected FIFO, set R ← its tuple, no write, go to MERGE.
- MERGE:
  - Both heads T: write R, no pop, go to TERM.
  - Otherwise: pop the selected FIFO. Sort the 4 elements {R, selected tuple}. Write the lower two (smaller in lane 0). R ← upper two.
- TERM: write 0, pop both, go to PRIME.
- Merge network: 4-element unsigned compare-and-swap network, combinational within one cycle.

## Timing
- Reset: state = PRIME, R = 0. o_fifo_1_read, o_fifo_2_read and o_out_fifo_write are 0 while i_rst_n = 0. o_data = 0.
- Reset mid-operation discards R and any partial sequence. Queued FIFO contents are not touched.
- Zero-cycle latency from pop to push: both occur at the same edge. One action per cycle maximum.
- Throughput is one output tuple per cycle in MERGE, with no bubbles when the input FIFOs are non-empty and the output is ready.
- Per sequence pair carrying N total tuples: N+1 output tuples (N data plus 1 terminator) and N+2 pops.
- If one stream has ended (its head is T) while the other FIFO is empty: stall. There is no speculative output.
- o_data is don't-care-free: it holds the last written value or 0 when no write is active.

## Configuration
- MERGER_2_CHECK_EN defined:
  - Adds output port o_order_err (1 bit), sticky and cleared only by reset.
  - Set when a popped non-T tuple has lane0 > lane1, or when a written data tuple's lane0 is less than the previous written data tuple's lane1 within the same sequence.
- Undefined: the port and the logic are absent. Behaviour is otherwise identical.

## Test plan
- Stream1 {1,3},{5,7},T; stream2 {2,4},{6,8},T; out always ready → writes {1,2},{3,4},{5,6},{7,8},{0,0}. Block ends in PRIME with both FIFOs empty.
- Stream1 {1,2},{3,4},T; stream2 {5,6},{7,8},T → {1,2},{3,4},{5,6},{7,8},{0,0}. Exercises early exhaustion of one input.
- Leading T on both inputs, then the first scenario back to back → {0,0} first, then the same 5 writes. Then the second scenario immediately → 5 more writes. Covers rearm after terminator.
- Equal heads: stream1 {3,3},T; stream2 {3,9},T → FIFO 1 popped first; writes {3,3},{3,9},{0,0}.
- Backpressure: hold i_fifo_out_ready = 0 for 3 cycles mid-sequence → no pops, no writes, R unchanged. Output stream after release matches the unstalled run.
- With MERGER_2_CHECK_EN defined: feed stream1 {5,1},T → o_order_err rises and stays 1 until i_rst_n pulses low. Reset asserted mid-sequence forces all strobes to 0 and state to PRIME.

Source files
------------

// File: rtl/merger_2_core.sv
// Two-input, two-lane streaming merge element: merges two sorted tuple streams into one.
// Optional MERGER_2_CHECK_EN adds a sticky o_order_err input/output ordering monitor.
module merger_2_core #(
    parameter int W = 32
) (
    input  logic           i_clk,
    input  logic           i_rst_n,
    input  logic [2*W-1:0] i_fifo_1,
    input  logic           i_fifo_1_empty,
    input  logic [2*W-1:0] i_fifo_2,
    input  logic           i_fifo_2_empty,
    input  logic           i_fifo_out_ready,
    output logic           o_fifo_1_read,
    output logic           o_fifo_2_read,
    output logic           o_out_fifo_write,
`ifdef MERGER_2_CHECK_EN
    output logic           o_order_err,
`endif
    output logic [2*W-1:0] o_data
);

    typedef enum logic [1:0] {S_PRIME, S_MERGE, S_TERM} state_t;

    state_t         r_state, w_state_nxt;
    logic [2*W-1:0] r_rem, w_rem_nxt;

    logic           w_h1_t, w_h2_t, w_both_t, w_avail, w_sel1;
    logic [W:0]     w_key1, w_key2;
    logic [2*W-1:0] w_sel_tup;
    logic [W-1:0]   w_a0, w_a1, w_b0, w_b1;
    logic [W-1:0]   w_lo0, w_x, w_y, w_hi1, w_lo1, w_hi0;
    logic [2*W-1:0] w_lo, w_hi;
    logic           w_rd1, w_rd2, w_wr;
    logic [2*W-1:0] w_data;

    assign w_h1_t   = (i_fifo_1 == '0);
    assign w_h2_t   = (i_fifo_2 == '0);
    assign w_both_t = w_h1_t & w_h2_t;
    assign w_avail  = i_rst_n & ~i_fifo_1_empty & ~i_fifo_2_empty;

    // Terminator sorts as +infinity via the extra MSB; ties go to FIFO 1.
    assign w_key1    = {w_h1_t, i_fifo_1[W-1:0]};
    assign w_key2    = {w_h2_t, i_fifo_2[W-1:0]};
    assign w_sel1    = (w_key1 <= w_key2);
    assign w_sel_tup = w_sel1 ? i_fifo_1 : i_fifo_2;

    // Odd-even merge of two sorted pairs: R = {a1,a0}, selected = {b1,b0}.
    assign w_a0  = r_rem[W-1:0];
    assign w_a1  = r_rem[2*W-1:W];
    assign w_b0  = w_sel_tup[W-1:0];
    assign w_b1  = w_sel_tup[2*W-1:W];
    assign w_lo0 = (w_a0 <= w_b0) ? w_a0 : w_b0;
    assign w_x   = (w_a0 <= w_b0) ? w_b0 : w_a0;
    assign w_y   = (w_a1 <= w_b1) ? w_a1 : w_b1;
    assign w_hi1 = (w_a1 <= w_b1) ? w_b1 : w_a1;
    assign w_lo1 = (w_x <= w_y) ? w_x : w_y;
    assign w_hi0 = (w_x <= w_y) ? w_y : w_x;
    assign w_lo  = {w_lo1, w_lo0};
    assign w_hi  = {w_hi1, w_hi0};

    always_comb begin
        w_rd1       = 1'b0;
        w_rd2       = 1'b0;
        w_wr        = 1'b0;
        w_data      = '0;
        w_state_nxt = r_state;
        w_rem_nxt   = r_rem;
        if (w_avail) begin
            case (r_state)
                S_PRIME: begin
                    if (w_both_t) begin
                        if (i_fifo_out_ready) begin
                            w_wr  = 1'b1;
                            w_rd1 = 1'b1;
                            w_rd2 = 1'b1;
                        end
                    end else begin
                        // Priming only loads R, so it needs no output space.
                        w_rd1       = w_sel1;
                        w_rd2       = ~w_sel1;
                        w_rem_nxt   = w_sel_tup;
                        w_state_nxt = S_MERGE;
                    end
                end
                S_MERGE: begin
                    if (i_fifo_out_ready) begin
                        w_wr = 1'b1;
                        if (w_both_t) begin
                            w_data      = r_rem;
                            w_state_nxt = S_TERM;
                        end else begin
                            w_rd1     = w_sel1;
                            w_rd2     = ~w_sel1;
                            w_data    = w_lo;
                            w_rem_nxt = w_hi;
                        end
                    end
                end
                S_TERM: begin
                    if (i_fifo_out_ready) begin
                        w_wr        = 1'b1;
                        w_rd1       = 1'b1;
                        w_rd2       = 1'b1;
                        w_state_nxt = S_PRIME;
                    end
                end
                default: w_state_nxt = S_PRIME;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_PRIME;
            r_rem   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_rem   <= w_rem_nxt;
        end
    end

    assign o_fifo_1_read    = w_rd1;
    assign o_fifo_2_read    = w_rd2;
    assign o_out_fifo_write = w_wr;
    assign o_data           = w_data;

`ifdef MERGER_2_CHECK_EN
    logic         r_err, r_prev_vld;
    logic [W-1:0] r_prev_hi;
    logic         w_pop_bad, w_wr_dat, w_wr_bad;

    assign w_pop_bad = (w_rd1 & ~w_h1_t & (i_fifo_1[W-1:0] > i_fifo_1[2*W-1:W])) |
                       (w_rd2 & ~w_h2_t & (i_fifo_2[W-1:0] > i_fifo_2[2*W-1:W]));
    assign w_wr_dat  = w_wr & (w_data != '0);
    assign w_wr_bad  = w_wr_dat & r_prev_vld & (w_data[W-1:0] < r_prev_hi);

    // A terminator write ends the sequence, so the next data write is unconstrained.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_err      <= 1'b0;
            r_prev_vld <= 1'b0;
            r_prev_hi  <= '0;
        end else begin
            r_err <= r_err | w_pop_bad | w_wr_bad;
            if (w_wr) begin
                r_prev_vld <= w_wr_dat;
                r_prev_hi  <= w_data[2*W-1:W];
            end
        end
    end

    assign o_order_err = r_err;
`endif

endmodule

// File: tb/tb_merger_2_core.sv
// Directed table-driven bench for merger_2_core with queue-modelled show-ahead FIFOs.
module tb_merger_2_core;
    localparam int W  = 32;
    localparam int DW = 2 * W;
    localparam logic [DW-1:0] GARB = 64'hDEAD_0001_DEAD_0002;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [DW-1:0] fifo_1, fifo_2, o_data;
    logic          fifo_1_empty, fifo_2_empty, ready;
    logic          rd1, rd2, wr;
`ifdef MERGER_2_CHECK_EN
    logic          order_err;
`endif

    always #5 clk = ~clk;

    merger_2_core #(.W(W)) dut (
        .i_clk            (clk),
        .i_rst_n          (rst_n),
        .i_fifo_1         (fifo_1),
        .i_fifo_1_empty   (fifo_1_empty),
        .i_fifo_2         (fifo_2),
        .i_fifo_2_empty   (fifo_2_empty),
        .i_fifo_out_ready (ready),
        .o_fifo_1_read    (rd1),
        .o_fifo_2_read    (rd2),
        .o_out_fifo_write (wr),
`ifdef MERGER_2_CHECK_EN
        .o_order_err      (order_err),
`endif
        .o_data           (o_data)
    );

    typedef struct packed {
        logic [3:0]           n1;
        logic [7:0][DW-1:0]   s1;
        logic [3:0]           n2;
        logic [7:0][DW-1:0]   s2;
        logic [3:0]           ne;
        logic [11:0][DW-1:0]  ex;
    } vec_t;

    vec_t          vecs[4];
    logic [DW-1:0] q1[$], q2[$], exp_q[$];
    int            n_chk = 0, n_fail = 0;

    function automatic logic [DW-1:0] tp(input int unsigned a, input int unsigned b);
        return {W'(b), W'(a)};
    endfunction

    task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic drive();
        fifo_1_empty = (q1.size() == 0);
        fifo_2_empty = (q2.size() == 0);
        fifo_1       = (q1.size() != 0) ? q1[0] : GARB;
        fifo_2       = (q2.size() != 0) ? q2[0] : GARB;
    endtask

    // One cycle: sample strobes mid-cycle, then apply the pops after the edge.
    task automatic step();
        logic r1, r2, w;
        logic [DW-1:0] d;
        @(negedge clk);
        r1 = rd1; r2 = rd2; w = wr; d = o_data;
        if (r1) chk("rd1_nonempty", DW'(q1.size() != 0), DW'(1));
        if (r2) chk("rd2_nonempty", DW'(q2.size() != 0), DW'(1));
        if (!ready) chk("stall_strobes", DW'({r1, r2, w}), DW'(0));
        if (w) begin
            if (exp_q.size() == 0) begin
                n_chk++; n_fail++;
                $display("FAIL extra_write: got %h expected no write", d);
            end else begin
                chk("wr_data", d, exp_q.pop_front());
            end
        end
        @(posedge clk); #1;
        if (r1 && q1.size() != 0) void'(q1.pop_front());
        if (r2 && q2.size() != 0) void'(q2.pop_front());
        drive();
    endtask

    task automatic drain(input int stall_at, input int stall_len);
        int cyc = 0;
        while (!(exp_q.size() == 0 && q1.size() == 0 && q2.size() == 0) && cyc < 100) begin
            ready = !(stall_at >= 0 && cyc >= stall_at && cyc < stall_at + stall_len);
            step();
            cyc++;
        end
        ready = 1'b1;
        chk("timeout", DW'(cyc < 100), DW'(1));
        chk("fifo1_drained", DW'(q1.size()), DW'(0));
        chk("fifo2_drained", DW'(q2.size()), DW'(0));
        chk("writes_missing", DW'(exp_q.size()), DW'(0));
        @(negedge clk);
        chk("idle_strobes", DW'({rd1, rd2, wr}), DW'(0));
        @(posedge clk); #1;
    endtask

    task automatic load(input int k);
        for (int i = 0; i < int'(vecs[k].n1); i++) q1.push_back(vecs[k].s1[i]);
        for (int i = 0; i < int'(vecs[k].n2); i++) q2.push_back(vecs[k].s2[i]);
        for (int i = 0; i < int'(vecs[k].ne); i++) exp_q.push_back(vecs[k].ex[i]);
        drive();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        for (int k = 0; k < 4; k++) vecs[k] = '0;
        // interleaved streams
        vecs[0].n1 = 3; vecs[0].s1[0] = tp(1,3); vecs[0].s1[1] = tp(5,7);
        vecs[0].n2 = 3; vecs[0].s2[0] = tp(2,4); vecs[0].s2[1] = tp(6,8);
        vecs[0].ne = 5; vecs[0].ex[0] = tp(1,2); vecs[0].ex[1] = tp(3,4);
        vecs[0].ex[2] = tp(5,6); vecs[0].ex[3] = tp(7,8);
        // stream 1 exhausts early
        vecs[1].n1 = 3; vecs[1].s1[0] = tp(1,2); vecs[1].s1[1] = tp(3,4);
        vecs[1].n2 = 3; vecs[1].s2[0] = tp(5,6); vecs[1].s2[1] = tp(7,8);
        vecs[1].ne = 5; vecs[1].ex[0] = tp(1,2); vecs[1].ex[1] = tp(3,4);
        vecs[1].ex[2] = tp(5,6); vecs[1].ex[3] = tp(7,8);
        // leading terminators, then both scenarios back to back
        vecs[2].n1 = 7; vecs[2].s1[1] = tp(1,3); vecs[2].s1[2] = tp(5,7);
        vecs[2].s1[4] = tp(1,2); vecs[2].s1[5] = tp(3,4);
        vecs[2].n2 = 7; vecs[2].s2[1] = tp(2,4); vecs[2].s2[2] = tp(6,8);
        vecs[2].s2[4] = tp(5,6); vecs[2].s2[5] = tp(7,8);
        vecs[2].ne = 11;
        vecs[2].ex[1] = tp(1,2); vecs[2].ex[2] = tp(3,4); vecs[2].ex[3] = tp(5,6);
        vecs[2].ex[4] = tp(7,8); vecs[2].ex[6] = tp(1,2); vecs[2].ex[7] = tp(3,4);
        vecs[2].ex[8] = tp(5,6); vecs[2].ex[9] = tp(7,8);
        // equal lane-0 heads: FIFO 1 wins the tie
        vecs[3].n1 = 2; vecs[3].s1[0] = tp(3,3);
        vecs[3].n2 = 2; vecs[3].s2[0] = tp(3,9);
        vecs[3].ne = 3; vecs[3].ex[0] = tp(3,3); vecs[3].ex[1] = tp(3,9);

        // reset with terminators presented: nothing may fire
        rst_n = 1'b0; ready = 1'b1;
        q1.push_back('0); q2.push_back('0); drive();
        @(negedge clk);
        chk("reset_strobes", DW'({rd1, rd2, wr}), DW'(0));
        chk("reset_data", o_data, DW'(0));
`ifdef MERGER_2_CHECK_EN
        chk("reset_err", DW'(order_err), DW'(0));
`endif
        @(posedge clk); #1;
        q1.delete(); q2.delete(); drive();
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int k = 0; k < 4; k++) begin
            load(k);
            drain(-1, 0);
        end

        // backpressure after two writes; output must match the unstalled run
        load(0);
        drain(3, 3);

        // one stream terminated, other empty: must stall without output
        q1.push_back(tp(1,3)); q1.push_back('0);
        q2.push_back(tp(2,4));
        exp_q.push_back(tp(1,2));
        drive();
        for (int i = 0; i < 3; i++) step();
        chk("pre_stall_writes", DW'(exp_q.size()), DW'(0));
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("t_stall_strobes", DW'({rd1, rd2, wr}), DW'(0));
            @(posedge clk); #1;
        end
        q2.push_back('0);
        exp_q.push_back(tp(3,4)); exp_q.push_back('0);
        drive();
        drain(-1, 0);

        // reset mid-sequence: R discarded, back in PRIME
        load(0);
        step(); step();
        rst_n = 1'b0;
        @(negedge clk);
        chk("midrst_strobes", DW'({rd1, rd2, wr}), DW'(0));
        chk("midrst_data", o_data, DW'(0));
        @(posedge clk); #1;
        q1.delete(); q2.delete(); exp_q.delete(); drive();
        rst_n = 1'b1;
        load(3);
        drain(-1, 0);

`ifdef MERGER_2_CHECK_EN
        chk("no_err_clean", DW'(order_err), DW'(0));
        q1.push_back(tp(5,1)); q1.push_back('0);
        q2.push_back('0);
        exp_q.push_back(tp(5,1)); exp_q.push_back('0);
        drive();
        drain(-1, 0);
        chk("err_set", DW'(order_err), DW'(1));
        for (int i = 0; i < 3; i++) @(posedge clk);
        #1;
        chk("err_sticky", DW'(order_err), DW'(1));
        rst_n = 1'b0; #2;
        chk("err_cleared", DW'(order_err), DW'(0));
        @(posedge clk); #1;
        rst_n = 1'b1;
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
